// File: rtl/sd_seq_pkg.sv
// Shared state, source-code and gating types for the discrete-input sample
// sequencer, plus the source-group to strobe/enable decode.
package sd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    CLEAR  = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } seq_state_t;

  localparam logic [2:0] SRC_CR      = 3'd0;
  localparam logic [2:0] SRC_GC      = 3'd1;
  localparam logic [2:0] SRC_DIN1516 = 3'd2;
  localparam logic [2:0] SRC_DIN12   = 3'd3;
  localparam logic [2:0] SRC_SSFB    = 3'd4;
  localparam logic [2:0] SRC_TS      = 3'd5;
  localparam logic [2:0] SRC_DV      = 3'd6;
  localparam logic [2:0] SRC_INVALID = 3'd7;

  typedef struct packed {
    logic w2;
    logic x2;
    logic y7;
  } strobe_t;

  typedef struct packed {
    logic pcg2v;
    logic pbg2v;
    logic paav;
    logic diad;
    logic ssa;
    logic tsa;
    logic crcav;
    logic icsd;
    logic icsdn;
    logic c4rdn;
  } enable_t;

  typedef struct packed {
    strobe_t strobe;
    enable_t enable;
  } gating_t;

  // Each valid group owns exactly one strobe line; the invalid code drives nothing.
  function automatic gating_t decode_src(input logic [2:0] src);
    gating_t g;
    g = 13'd0;
    case (src)
      SRC_CR: begin
        g.strobe.x2 = 1'b1; g.enable.icsd = 1'b1; g.enable.pcg2v = 1'b1; g.enable.crcav = 1'b1;
      end
      SRC_GC: begin
        g.strobe.x2 = 1'b1; g.enable.icsdn = 1'b1; g.enable.pcg2v = 1'b1; g.enable.crcav = 1'b1;
      end
      SRC_DIN1516: begin
        g.strobe.x2 = 1'b1; g.enable.pcg2v = 1'b1; g.enable.diad = 1'b1;
      end
      SRC_DIN12: begin
        g.strobe.y7 = 1'b1; g.enable.pbg2v = 1'b1; g.enable.diad = 1'b1;
      end
      SRC_SSFB: begin
        g.strobe.x2 = 1'b1; g.enable.pcg2v = 1'b1; g.enable.ssa = 1'b1;
      end
      SRC_TS: begin
        g.strobe.w2 = 1'b1; g.enable.pcg2v = 1'b1; g.enable.tsa = 1'b1;
      end
      SRC_DV: begin
        g.strobe.y7 = 1'b1; g.enable.paav = 1'b1; g.enable.c4rdn = 1'b1;
      end
      default: g = 13'd0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sd_seq_arbiter.sv
// Two-way round-robin arbiter for the processor read path (A) and the
// telemetry scan (B); the pointer remembers which side won last.
module sd_seq_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic grant_a,
  output logic grant_b
);

  logic last_b_r;

  // A lone requester wins outright; a tie goes to the side not served last.
  always_comb begin
    grant_a = req_a & (~req_b | last_b_r);
    grant_b = req_b & (~req_a | ~last_b_r);
  end

  // Pointer starts at B so that A is favoured on the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_r <= 1'b1;
    end else if (en && grant_b) begin
      last_b_r <= 1'b1;
    end else if (en && grant_a) begin
      last_b_r <= 1'b0;
    end else begin
      last_b_r <= last_b_r;
    end
  end

endmodule

// File: rtl/sd_sample_sequencer.sv
// Sequences one sampling cycle of the ML5/ML6 switch-selector sampler:
// grant, latch clear, source setup, strobe, V1 hold, then DONE.
module sd_sample_sequencer
  import sd_seq_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       REQA,
  input  logic [2:0] SRCA,
  input  logic       REQB,
  input  logic [2:0] SRCB,
  output logic       ACKA,
  output logic       ACKB,
  output logic       BUSY,
  output logic       DONE,
  output logic       OWNER,
  output logic       SRCERR,
  output logic       W2,
  output logic       X2,
  output logic       Y7,
  output logic       Z2,
  output logic       RESMV,
  output logic       MLAV,
  output logic       V1,
  output logic       PCG2V,
  output logic       PBG2V,
  output logic       PAAV,
  output logic       DIAD,
  output logic       SSA,
  output logic       TSA,
  output logic       CRCAV,
  output logic       ICSD,
  output logic       ICSDN,
  output logic       C4RDN
);

  localparam logic [7:0] SLOT_LOAD = 8'(SLOT_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  seq_state_t state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [2:0] src_r, src_s;
  logic       owner_s;
  logic       arb_en_s;
  logic       grant_a_s, grant_b_s;
  logic       clear_s, hold_s;
  strobe_t    strobe_s;
  enable_t    enable_s;
  gating_t    gate_s;

  sd_seq_arbiter u_arb (
    .clk     (SIM_CLK),
    .rst_n   (SIM_RST),
    .req_a   (REQA),
    .req_b   (REQB),
    .en      (arb_en_s),
    .grant_a (grant_a_s),
    .grant_b (grant_b_s)
  );

  // Next state, phase counter and latched source/owner.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    src_s    = src_r;
    owner_s  = OWNER;
    arb_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (REQA || REQB) begin
          arb_en_s = 1'b1;
          state_s  = GRANT;
          cnt_s    = 8'd0;
          if (grant_b_s) begin
            src_s   = SRCB;
            owner_s = 1'b1;
          end else begin
            src_s   = SRCA;
            owner_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (src_r == SRC_INVALID) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
          cnt_s   = SLOT_LOAD;
        end
      end
      CLEAR, SETUP, STROBE: begin
        if (cnt_r == 8'd0) begin
          state_s = (state_r == CLEAR) ? SETUP : ((state_r == SETUP) ? STROBE : HOLD);
          cnt_s   = (state_r == STROBE) ? HOLD_LOAD : SLOT_LOAD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_r == 8'd0) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Gating seen by the sampler in the upcoming state; registered below.
  always_comb begin
    gate_s   = decode_src(src_s);
    clear_s  = 1'b0;
    hold_s   = 1'b0;
    strobe_s = 3'b000;
    enable_s = 10'b0000000000;
    case (state_s)
      CLEAR:  clear_s = 1'b1;
      SETUP: begin
        hold_s   = 1'b1;
        enable_s = gate_s.enable;
      end
      STROBE: begin
        hold_s   = 1'b1;
        enable_s = gate_s.enable;
        strobe_s = gate_s.strobe;
      end
      HOLD:   hold_s = 1'b1;
      default: begin
        clear_s = 1'b0;
        hold_s  = 1'b0;
      end
    endcase
  end

  // State and fully registered outputs; reset aborts any cycle in flight.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      src_r   <= 3'd0;
      OWNER   <= 1'b0;
      ACKA    <= 1'b0;
      ACKB    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      SRCERR  <= 1'b0;
      {W2, X2, Y7}       <= 3'b000;
      {Z2, RESMV, MLAV}  <= 3'b000;
      V1                 <= 1'b0;
      {PCG2V, PBG2V, PAAV, DIAD, SSA, TSA, CRCAV, ICSD, ICSDN, C4RDN} <= 10'b0000000000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      src_r   <= src_s;
      OWNER   <= owner_s;
      ACKA    <= arb_en_s & grant_a_s;
      ACKB    <= arb_en_s & grant_b_s;
      BUSY    <= (state_s != IDLE);
      DONE    <= (state_s == HOLD) && (cnt_s == 8'd0);
      SRCERR  <= (state_r == GRANT) && (src_r == SRC_INVALID);
      {W2, X2, Y7}       <= strobe_s;
      {Z2, RESMV, MLAV}  <= {3{clear_s}};
      V1                 <= hold_s;
      {PCG2V, PBG2V, PAAV, DIAD, SSA, TSA, CRCAV, ICSD, ICSDN, C4RDN} <= enable_s;
    end
  end

endmodule

// File: tb/tb_sd_sample_sequencer.sv
// Scoreboard bench: two sequencer instances (default and minimum timing);
// a negedge monitor profiles each cycle and checks it against queued expectations.
module tb_sd_sample_sequencer;

  localparam int S0 = 4;
  localparam int H0 = 8;
  localparam int S1 = 1;
  localparam int H1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] reqa, reqb;
  logic [2:0] srca [2];
  logic [2:0] srcb [2];
  logic [1:0] acka, ackb, busy, done, owner, srcerr;
  logic [1:0] w2, x2, y7, z2, resmv, mlav, v1;
  logic [1:0] pcg2v, pbg2v, paav, diad, ssa, tsa, crcav, icsd, icsdn, c4rdn;
  logic [22:0] outv [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sd_sample_sequencer #(
      .SLOT_CYCLES((g == 0) ? S0 : S1),
      .HOLD_CYCLES((g == 0) ? H0 : H1)
    ) dut (
      .SIM_CLK(clk), .SIM_RST(rst_n),
      .REQA(reqa[g]), .SRCA(srca[g]), .REQB(reqb[g]), .SRCB(srcb[g]),
      .ACKA(acka[g]), .ACKB(ackb[g]), .BUSY(busy[g]), .DONE(done[g]),
      .OWNER(owner[g]), .SRCERR(srcerr[g]),
      .W2(w2[g]), .X2(x2[g]), .Y7(y7[g]),
      .Z2(z2[g]), .RESMV(resmv[g]), .MLAV(mlav[g]), .V1(v1[g]),
      .PCG2V(pcg2v[g]), .PBG2V(pbg2v[g]), .PAAV(paav[g]), .DIAD(diad[g]),
      .SSA(ssa[g]), .TSA(tsa[g]), .CRCAV(crcav[g]), .ICSD(icsd[g]),
      .ICSDN(icsdn[g]), .C4RDN(c4rdn[g])
    );
    assign outv[g] = {acka[g], ackb[g], busy[g], done[g], owner[g], srcerr[g],
                      w2[g], x2[g], y7[g], z2[g], resmv[g], mlav[g], v1[g],
                      pcg2v[g], pbg2v[g], paav[g], diad[g], ssa[g], tsa[g],
                      crcav[g], icsd[g], icsdn[g], c4rdn[g]};
  end

  // Hand-derived gating per code: strobe {W2,X2,Y7};
  // enables {PCG2V,PBG2V,PAAV,DIAD,SSA,TSA,CRCAV,ICSD,ICSDN,C4RDN}.
  logic [2:0] stb_tab [8] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
  logic [9:0] en_tab  [8] = '{10'b1000001100, 10'b1000001010, 10'b1001000000, 10'b0101000000,
                              10'b1000100000, 10'b1000010000, 10'b0010000001, 10'b0000000000};

  typedef struct packed {
    logic       inst;
    logic       ack;
    logic       err;
    logic [2:0] stb;
    logic [9:0] en;
    logic [7:0] gap;
  } exp_t;

  typedef struct {
    bit         active;
    int         idx, since, gap;
    bit         ack, viol;
    int         cf, cc, ef, ec, sf, sc, vf, vc;
    logic [2:0] so;
    logic [9:0] eo;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc [2];
  int   stray [2];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec = n_vec + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int pending(input int g);
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i].inst == g[0]) n++;
    return n;
  endfunction

  task automatic mon_step(input int g);
    logic [2:0] stb, clr;
    logic [9:0] en;
    exp_t e;
    int k, s, h, len;
    string p;
    p   = $sformatf("u%0d.", g);
    s   = (g == 0) ? S0 : S1;
    h   = (g == 0) ? H0 : H1;
    stb = {w2[g], x2[g], y7[g]};
    clr = {z2[g], resmv[g], mlav[g]};
    en  = {pcg2v[g], pbg2v[g], paav[g], diad[g], ssa[g], tsa[g], crcav[g], icsd[g], icsdn[g], c4rdn[g]};
    if (!rst_n) begin
      acc[g].active = 1'b0;
      acc[g].since  = 0;
      return;
    end
    acc[g].since = acc[g].since + 1;
    if (acka[g] || ackb[g]) begin
      chk({p, "ack_clean"}, int'(acc[g].active) + int'(acka[g] & ackb[g]), 0);
      acc[g].active = 1'b1; acc[g].idx = 1; acc[g].ack = ackb[g]; acc[g].gap = acc[g].since;
      acc[g].viol = 1'b0; acc[g].so = 3'b000; acc[g].eo = 10'd0;
      acc[g].cf = 0; acc[g].cc = 0; acc[g].ef = 0; acc[g].ec = 0;
      acc[g].sf = 0; acc[g].sc = 0; acc[g].vf = 0; acc[g].vc = 0;
    end else if (acc[g].active) begin
      acc[g].idx = acc[g].idx + 1;
    end
    if (acc[g].active) begin
      if (|clr) begin if (acc[g].cc == 0) acc[g].cf = acc[g].idx; acc[g].cc = acc[g].cc + 1; end
      if (|en)  begin if (acc[g].ec == 0) acc[g].ef = acc[g].idx; acc[g].ec = acc[g].ec + 1; end
      if (|stb) begin if (acc[g].sc == 0) acc[g].sf = acc[g].idx; acc[g].sc = acc[g].sc + 1; end
      if (v1[g]) begin if (acc[g].vc == 0) acc[g].vf = acc[g].idx; acc[g].vc = acc[g].vc + 1; end
      acc[g].so = acc[g].so | stb;
      acc[g].eo = acc[g].eo | en;
      if ((|stb && |clr) || ($countones(stb) > 1) || (clr != 3'b000 && clr != 3'b111)) acc[g].viol = 1'b1;
    end else if (|{stb, clr, en, v1[g]}) begin
      stray[g] = stray[g] + 1;
    end
    if (done[g] || srcerr[g]) begin
      acc[g].since = 0;
      k = -1;
      foreach (exp_q[i]) if (k < 0 && exp_q[i].inst == g[0]) k = i;
      chk({p, "response_expected"}, int'(acc[g].active && k >= 0), 1);
      if (acc[g].active && k >= 0) begin
        e = exp_q[k];
        exp_q.delete(k);
        len = e.err ? 2 : 1 + 3 * s + h;
        chk({p, "ack_side"},     acc[g].ack, e.ack);
        chk({p, "owner"},        owner[g], e.ack);
        chk({p, "srcerr"},       srcerr[g], e.err);
        chk({p, "done"},         done[g], !e.err);
        chk({p, "busy_at_end"},  busy[g], !e.err);
        chk({p, "length"},       acc[g].idx, len);
        chk({p, "strobe_set"},   acc[g].so, e.stb);
        chk({p, "enable_set"},   acc[g].eo, e.en);
        chk({p, "clear_first"},  acc[g].cf, e.err ? 0 : 2);
        chk({p, "clear_cnt"},    acc[g].cc, e.err ? 0 : s);
        chk({p, "enable_first"}, acc[g].ef, e.err ? 0 : 2 + s);
        chk({p, "enable_cnt"},   acc[g].ec, e.err ? 0 : 2 * s);
        chk({p, "strobe_first"}, acc[g].sf, e.err ? 0 : 2 + 2 * s);
        chk({p, "strobe_cnt"},   acc[g].sc, e.err ? 0 : s);
        chk({p, "v1_first"},     acc[g].vf, e.err ? 0 : 2 + s);
        chk({p, "v1_cnt"},       acc[g].vc, e.err ? 0 : 2 * s + h);
        chk({p, "glitch"},       acc[g].viol, 0);
        if (e.gap != 8'd0) chk({p, "grant_gap"}, acc[g].gap, e.gap);
      end
      acc[g].active = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) mon_step(g);
  end

  task automatic issue(input int g, input bit who, input logic [2:0] src, input bit push, input logic [7:0] gap);
    exp_t e;
    if (push) begin
      e.inst = g[0]; e.ack = who; e.err = (src == 3'd7);
      e.stb = stb_tab[src]; e.en = en_tab[src]; e.gap = gap;
      exp_q.push_back(e);
    end
    if (who) begin srcb[g] = src; reqb[g] = 1'b1; end
    else     begin srca[g] = src; reqa[g] = 1'b1; end
  endtask

  task automatic wait_ack(input int g, input bit who);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (who ? ackb[g] : acka[g]) begin
        if (who) reqb[g] = 1'b0; else reqa[g] = 1'b0;
        return;
      end
    end
    chk($sformatf("u%0d.ack_timeout", g), 0, 1);
  endtask

  task automatic wait_quiet(input int g);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!acc[g].active && pending(g) == 0 && !reqa[g] && !reqb[g]) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk($sformatf("u%0d.quiet_timeout", g), pending(g), 0);
  endtask

  bit last_b;
  bit first_b;

  initial begin
    rst_n = 1'b0; reqa = 2'b00; reqb = 2'b00;
    srca[0] = 3'd0; srca[1] = 3'd0; srcb[0] = 3'd0; srcb[1] = 3'd0;
    stray[0] = 0; stray[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("u0.reset_outputs", int'(outv[0]), 0);
    chk("u1.reset_outputs", int'(outv[1]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie straight after reset: A first, B one idle clock after DONE.
    issue(0, 1'b0, 3'd5, 1'b1, 8'd0);
    issue(0, 1'b1, 3'd3, 1'b1, 8'd2);
    fork wait_ack(0, 1'b0); wait_ack(0, 1'b1); join
    wait_quiet(0);

    issue(0, 1'b0, 3'd0, 1'b1, 8'd0); wait_ack(0, 1'b0); wait_quiet(0);
    issue(0, 1'b1, 3'd7, 1'b1, 8'd0); wait_ack(0, 1'b1); wait_quiet(0);

    // All valid codes under tied requests; the side not served last wins.
    last_b = 1'b1;
    for (int c = 0; c < 7; c++) begin
      first_b = ~last_b;
      issue(0, first_b, 3'(c), 1'b1, 8'd0);
      issue(0, ~first_b, 3'(6 - c), 1'b1, 8'd2);
      fork wait_ack(0, 1'b0); wait_ack(0, 1'b1); join
      wait_quiet(0);
      last_b = ~first_b;
    end

    // Reset in the middle of STROBE for source 4, with a request held over.
    issue(0, 1'b0, 3'd4, 1'b0, 8'd0); wait_ack(0, 1'b0);
    for (int n = 0; n < 100 && !x2[0]; n++) @(negedge clk);
    chk("u0.strobe_reached", x2[0], 1);
    issue(0, 1'b0, 3'd2, 1'b1, 8'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("u0.abort_outputs", int'(outv[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ack(0, 1'b0); wait_quiet(0);

    // Minimum timing instance.
    issue(1, 1'b1, 3'd6, 1'b1, 8'd0); wait_ack(1, 1'b1); wait_quiet(1);
    issue(1, 1'b0, 3'd0, 1'b1, 8'd0); wait_ack(1, 1'b0); wait_quiet(1);

    repeat (4) @(posedge clk);
    chk("leftover_expectations", exp_q.size(), 0);
    chk("u0.gating_outside_cycle", stray[0], 0);
    chk("u1.gating_outside_cycle", stray[1], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
